// File: rtl/vector_decode_stage_pkg.sv
// Shared encodings and decoded-control struct for the vector decode stage.
// Optional same-cycle writeback bypass is enabled with DECODE_BYPASS_EN.
package vector_decode_stage_pkg;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_MEM  = 2'b01,
    OP_JMP  = 2'b10,
    OP_ALUI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    JMP_ABS  = 2'b00,
    JMP_COND = 2'b01,
    JMP_REG  = 2'b10,
    JMP_CALL = 2'b11
  } jmp_e;

  typedef struct packed {
    logic       wreg;
    logic       rmem;
    logic       wmem;
    logic       cond;
    logic [1:0] jmp;
    logic [2:0] alu;
    logic       use_a;   // rs2 is a live source
    logic       use_b;   // rs3 is a live source
    logic       pc_a;    // operand A comes from pc
    logic       imm_b;   // operand B comes from the immediate
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [1:0] op, input logic [1:0] inst);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ALU: begin
        c.wreg  = 1'b1;
        c.use_a = 1'b1;
        c.use_b = 1'b1;
        c.alu   = {op[1], inst};
      end
      OP_ALUI: begin
        c.wreg  = 1'b1;
        c.use_a = 1'b1;
        c.imm_b = 1'b1;
        c.alu   = {op[1], inst};
      end
      OP_MEM: begin
        c.use_a = 1'b1;
        if (inst[0]) begin
          c.rmem  = 1'b1;
          c.wreg  = 1'b1;
          c.imm_b = 1'b1;
        end else begin
          c.wmem  = 1'b1;
          c.use_b = 1'b1;
        end
      end
      default: begin
        c.jmp   = inst;
        c.cond  = (inst == JMP_COND);
        c.imm_b = 1'b1;
        c.pc_a  = (inst != JMP_REG);
        c.use_a = (inst == JMP_REG);
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vector_decode_stage_if.sv
// Bundle of issue, writeback, flush and result signals of the vector decode stage.
// master = upstream/downstream environment, slave = the decode stage itself.
interface vector_decode_stage_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int NREG   = 16,
  parameter int IMM_W  = 27
);
  localparam int VW = LANES * LANE_W;
  localparam int RW = $clog2(NREG);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [1:0]       inst;
  logic             vf;
  logic [RW-1:0]    rd;
  logic [RW-1:0]    rs2;
  logic [RW-1:0]    rs3;
  logic [IMM_W-1:0] imm;
  logic [31:0]      pc;

  logic             wb_en;
  logic             wb_vf;
  logic [RW-1:0]    wb_rd;
  logic [VW-1:0]    wb_data;

  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    out_opa;
  logic [VW-1:0]    out_opb;
  logic [RW-1:0]    out_rd;
  logic             out_vf;
  logic             out_wreg;
  logic             out_rmem;
  logic             out_wmem;
  logic             out_cond;
  logic [1:0]       out_jmp;
  logic [2:0]       out_alu;

  modport master (
    output in_valid, op, inst, vf, rd, rs2, rs3, imm, pc,
    output wb_en, wb_vf, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_opa, out_opb, out_rd, out_vf,
    input  out_wreg, out_rmem, out_wmem, out_cond, out_jmp, out_alu
  );

  modport slave (
    input  in_valid, op, inst, vf, rd, rs2, rs3, imm, pc,
    input  wb_en, wb_vf, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_opa, out_opb, out_rd, out_vf,
    output out_wreg, out_rmem, out_wmem, out_cond, out_jmp, out_alu
  );

endinterface

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per register for the scalar (0) and vector (1) files.
// Set from an accepted writer beats both writeback clear and flush kill on the same bit.
module decode_scoreboard #(
  parameter int NREG = 16,
  parameter int RW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic                 set_vf,
  input  logic [RW-1:0]        set_rd,
  input  logic                 clr_en,
  input  logic                 clr_vf,
  input  logic [RW-1:0]        clr_rd,
  input  logic                 kill_en,
  input  logic                 kill_vf,
  input  logic [RW-1:0]        kill_rd,
  output logic [1:0][NREG-1:0] pend
);

  logic [1:0][NREG-1:0] pend_q;
  logic [1:0][NREG-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en)  pend_d[clr_vf][clr_rd]   = 1'b0;
    if (kill_en) pend_d[kill_vf][kill_rd] = 1'b0;
    if (set_en)  pend_d[set_vf][set_rd]   = 1'b1;
    pend_d[0][0] = 1'b0;
    pend_d[1][0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend = pend_q;

endmodule

// File: rtl/vector_decode_stage.sv
// Single-stage vector decode: register read, hazard check against the scoreboard, output latch.
// Define DECODE_BYPASS_EN to forward a same-cycle writeback into the source operands.
module vector_decode_stage
  import vector_decode_stage_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int NREG   = 16,
  parameter int IMM_W  = 27
) (
  input logic                  clk,
  input logic                  rst_n,
  vector_decode_stage_if.slave bus
);

  localparam int VW = LANES * LANE_W;
  localparam int RW = $clog2(NREG);
`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [VW-1:0] pick(input logic [RW-1:0] rs, input logic vsel,
                                         input logic [VW-1:0] vval, input logic [LANE_W-1:0] sval,
                                         input logic byp, input logic [VW-1:0] wdata);
    pick = '0;
    if (rs != '0) begin
      if (byp) pick = vsel ? wdata : VW'(wdata[LANE_W-1:0]);
      else     pick = vsel ? vval  : VW'(sval);
    end
  endfunction

  ctrl_t                ctrl;
  logic [1:0][NREG-1:0] pend;
  logic [VW-1:0]        vrf_q [NREG];
  logic [VW-1:0]        vrf_d [NREG];
  logic [LANE_W-1:0]    srf_q [NREG];
  logic [LANE_W-1:0]    srf_d [NREG];
  logic [LANE_W-1:0]    imm_sx;
  logic [VW-1:0]        rs2_val, rs3_val, imm_vec, pc_vec, opa, opb;
  logic                 hit_a, hit_b, hz_a, hz_b, hz_w, hazard, accept, in_ready;

  logic                 out_valid_q, out_valid_d;
  logic [VW-1:0]        out_opa_q, out_opa_d, out_opb_q, out_opb_d;
  logic [RW-1:0]        out_rd_q, out_rd_d;
  logic                 out_vf_q, out_vf_d;
  ctrl_t                out_ctrl_q, out_ctrl_d;

  always_comb begin
    ctrl    = decode_ctrl(bus.op, bus.inst);
    hit_a   = bus.wb_en && (bus.wb_vf == bus.vf) && (bus.wb_rd == bus.rs2) && (bus.rs2 != '0);
    hit_b   = bus.wb_en && (bus.wb_vf == bus.vf) && (bus.wb_rd == bus.rs3) && (bus.rs3 != '0);
    rs2_val = pick(bus.rs2, bus.vf, vrf_q[bus.rs2], srf_q[bus.rs2], BYPASS && hit_a, bus.wb_data);
    rs3_val = pick(bus.rs3, bus.vf, vrf_q[bus.rs3], srf_q[bus.rs3], BYPASS && hit_b, bus.wb_data);
    imm_sx  = LANE_W'($signed(bus.imm));
    imm_vec = VW'(imm_sx);
    pc_vec  = VW'(LANE_W'(bus.pc));
    opa     = ctrl.pc_a ? pc_vec : rs2_val;
    opb     = ctrl.imm_b ? imm_vec : (ctrl.use_b ? rs3_val : '0);
    // Without bypass a source being written this cycle waits for the file update.
    hz_a    = ctrl.use_a && (BYPASS ? (pend[bus.vf][bus.rs2] && !hit_a)
                                    : (pend[bus.vf][bus.rs2] || hit_a));
    hz_b    = ctrl.use_b && (BYPASS ? (pend[bus.vf][bus.rs3] && !hit_b)
                                    : (pend[bus.vf][bus.rs3] || hit_b));
    hz_w    = ctrl.wreg && pend[bus.vf][bus.rd];
    hazard  = hz_a || hz_b || hz_w;
  end

  // Handshake: a transfer happens on an edge where valid && ready; in_ready never
  // depends on in_valid, and out_* hold steady while out_valid && !out_ready.
  assign in_ready = !hazard && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_opa_d   = out_opa_q;
    out_opb_d   = out_opb_q;
    out_rd_d    = out_rd_q;
    out_vf_d    = out_vf_q;
    out_ctrl_d  = out_ctrl_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_opa_d   = opa;
      out_opb_d   = opb;
      out_rd_d    = bus.rd;
      out_vf_d    = bus.vf;
      out_ctrl_d  = ctrl;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    srf_d = srf_q;
    vrf_d = vrf_q;
    if (bus.wb_en && (bus.wb_rd != '0)) begin
      if (bus.wb_vf) vrf_d[bus.wb_rd] = bus.wb_data;
      else           srf_d[bus.wb_rd] = bus.wb_data[LANE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_opa_q   <= '0;
      out_opb_q   <= '0;
      out_rd_q    <= '0;
      out_vf_q    <= 1'b0;
      out_ctrl_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        vrf_q[i] <= '0;
        srf_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_opa_q   <= out_opa_d;
      out_opb_q   <= out_opb_d;
      out_rd_q    <= out_rd_d;
      out_vf_q    <= out_vf_d;
      out_ctrl_q  <= out_ctrl_d;
      vrf_q       <= vrf_d;
      srf_q       <= srf_d;
    end
  end

  decode_scoreboard #(.NREG(NREG), .RW(RW)) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (accept && ctrl.wreg),
    .set_vf  (bus.vf),
    .set_rd  (bus.rd),
    .clr_en  (bus.wb_en),
    .clr_vf  (bus.wb_vf),
    .clr_rd  (bus.wb_rd),
    .kill_en (bus.flush && out_valid_q && out_ctrl_q.wreg),
    .kill_vf (out_vf_q),
    .kill_rd (out_rd_q),
    .pend    (pend)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_opa   = out_opa_q;
  assign bus.out_opb   = out_opb_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_vf    = out_vf_q;
  assign bus.out_wreg  = out_ctrl_q.wreg;
  assign bus.out_rmem  = out_ctrl_q.rmem;
  assign bus.out_wmem  = out_ctrl_q.wmem;
  assign bus.out_cond  = out_ctrl_q.cond;
  assign bus.out_jmp   = out_ctrl_q.jmp;
  assign bus.out_alu   = out_ctrl_q.alu;

endmodule

// File: tb/tb_vector_decode_stage.sv
// Directed bench for vector_decode_stage: default build plus a LANES=8/NREG=32 instance.
// Timing expectations follow DECODE_BYPASS_EN when it is defined for the build.
module tb_vector_decode_stage;
  import vector_decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vector_decode_stage_if #(.LANES(4), .LANE_W(32), .NREG(16), .IMM_W(27)) bus ();
  vector_decode_stage_if #(.LANES(8), .LANE_W(32), .NREG(32), .IMM_W(27)) bus8 ();

  vector_decode_stage #(.LANES(4), .LANE_W(32), .NREG(16), .IMM_W(27)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  vector_decode_stage #(.LANES(8), .LANE_W(32), .NREG(32), .IMM_W(27)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] VD  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [255:0] V8D = 256'h8888_8888_7777_7777_6666_6666_5555_5555_4444_4444_3333_3333_2222_2222_1111_1111;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.op = 0; bus.inst = 0; bus.vf = 0; bus.rd = 0;
    bus.rs2 = 0; bus.rs3 = 0; bus.imm = 0; bus.pc = 0;
    bus.wb_en = 0; bus.wb_vf = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.flush = 0; bus.out_ready = 1;
    bus8.in_valid = 0; bus8.op = 0; bus8.inst = 0; bus8.vf = 0; bus8.rd = 0;
    bus8.rs2 = 0; bus8.rs3 = 0; bus8.imm = 0; bus8.pc = 0;
    bus8.wb_en = 0; bus8.wb_vf = 0; bus8.wb_rd = 0; bus8.wb_data = 0;
    bus8.flush = 0; bus8.out_ready = 1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] inst, input logic vf,
                       input logic [3:0] rd, input logic [3:0] rs2, input logic [3:0] rs3,
                       input logic [26:0] imm, input logic [31:0] pc);
    bus.in_valid = 1; bus.op = op; bus.inst = inst; bus.vf = vf; bus.rd = rd;
    bus.rs2 = rs2; bus.rs3 = rs3; bus.imm = imm; bus.pc = pc;
  endtask

  task automatic wb(input logic vf, input logic [3:0] rd, input logic [127:0] data);
    bus.wb_en = 1; bus.wb_vf = vf; bus.wb_rd = rd; bus.wb_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    settle();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_opa", bus.out_opa, 0);
    check("rst_out_fields", {bus.out_rd, bus.out_alu, bus.out_jmp, bus.out_wreg}, 0);
    tick();
    rst_n = 1'b1;
    settle();
    check("rst_in_ready", bus.in_ready, 1);

    // Scenario 1: scalar writeback then ALU read; upper wb_data bits must be dropped
    tick();
    wb(0, 3, {96'hDEAD_BEEF_0000_0000_1111_2222, 32'h15});
    tick();
    bus.wb_en = 0;
    issue(OP_ALU, 2'b01, 0, 1, 3, 0, 0, 0);
    settle();
    check("s1_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    settle();
    check("s1_valid", bus.out_valid, 1);
    check("s1_opa", bus.out_opa, 128'h15);
    check("s1_opb", bus.out_opb, 0);
    check("s1_ctl", {bus.out_alu, bus.out_wreg, bus.out_rd}, {3'b001, 1'b1, 4'd1});
    tick();
    wb(0, 1, 0);
    settle();
    check("s1_drain", bus.out_valid, 0);
    tick();
    bus.wb_en = 0;

    // Scenario 2: vector load then dependent ALU
    issue(OP_MEM, 2'b01, 1, 5, 0, 0, 0, 0);
    tick();
    issue(OP_ALU, 2'b00, 1, 6, 5, 0, 0, 0);
    settle();
    check("s2_load_ctl", {bus.out_rmem, bus.out_wreg, bus.out_wmem, bus.out_vf}, 4'b1101);
    check("s2_stall0", bus.in_ready, 0);
    tick();
    settle();
    check("s2_stall1", bus.in_ready, 0);
    tick();
    wb(1, 5, VD);
    settle();
`ifdef DECODE_BYPASS_EN
    check("s2_byp_ready", bus.in_ready, 1);
    tick();
    bus.wb_en = 0;
    bus.in_valid = 0;
`else
    check("s2_wb_stall", bus.in_ready, 0);
    tick();
    bus.wb_en = 0;
    settle();
    check("s2_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
`endif
    settle();
    check("s2_valid", bus.out_valid, 1);
    check("s2_opa", bus.out_opa, VD);
    check("s2_rd_vf", {bus.out_rd, bus.out_vf}, {4'd6, 1'b1});
    tick();
    wb(1, 6, 0);
    tick();
    bus.wb_en = 0;

    // Scenario 3: immediates and jumps
    issue(OP_ALUI, 2'b10, 0, 2, 0, 0, 27'h7FFFFFF, 0);
    tick();
    issue(OP_JMP, 2'b01, 0, 0, 0, 0, 27'h4000000, 32'h1000);
    settle();
    check("s3_imm_neg", bus.out_opb, 128'hFFFF_FFFF);
    check("s3_alui_alu", bus.out_alu, 3'b110);
    check("s3_alui_opa", bus.out_opa, 0);
    tick();
    issue(OP_JMP, 2'b10, 0, 0, 3, 0, 27'h10, 32'h2000);
    settle();
    check("s3_jc_opa", bus.out_opa, 128'h1000);
    check("s3_jc_opb", bus.out_opb, 128'hFC00_0000);
    check("s3_jc_ctl", {bus.out_cond, bus.out_jmp, bus.out_wreg}, {1'b1, 2'b01, 1'b0});
    tick();
    bus.in_valid = 0;
    settle();
    check("s3_jr_opa", bus.out_opa, 128'h15);
    check("s3_jr_ctl", {bus.out_cond, bus.out_jmp}, {1'b0, 2'b10});
    tick();
    wb(0, 2, 0);
    tick();
    bus.wb_en = 0;

    // Scenario 4: downstream backpressure for three cycles
    issue(OP_ALU, 2'b11, 0, 8, 3, 0, 0, 0);
    tick();
    bus.out_ready = 0;
    issue(OP_ALUI, 2'b00, 0, 9, 0, 0, 27'd5, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("s4_hold_ready", bus.in_ready, 0);
      check("s4_hold_fields", {bus.out_valid, bus.out_rd, bus.out_alu, bus.out_opa},
            {1'b1, 4'd8, 3'b011, 128'h15});
      tick();
    end
    bus.out_ready = 1;
    settle();
    check("s4_release_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    settle();
    check("s4_second", {bus.out_valid, bus.out_rd, bus.out_alu, bus.out_opb},
          {1'b1, 4'd9, 3'b100, 128'h5});

    // Scenario 5: flush a held load to r7
    issue(OP_MEM, 2'b01, 0, 7, 0, 0, 0, 0);
    tick();
    bus.out_ready = 0;
    bus.flush = 1;
    issue(OP_ALU, 2'b00, 0, 11, 3, 0, 0, 0);
    settle();
    check("s5_held", {bus.out_valid, bus.out_rd}, {1'b1, 4'd7});
    check("s5_flush_block", bus.in_ready, 0);
    tick();
    bus.flush = 0;
    issue(OP_ALU, 2'b00, 0, 10, 7, 0, 0, 0);
    settle();
    check("s5_killed", bus.out_valid, 0);
    check("s5_r7_free", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    settle();
    check("s5_next", {bus.out_valid, bus.out_rd, bus.out_opa}, {1'b1, 4'd10, 128'h0});
    bus.out_ready = 1;

    // WAW on r8 (still pending from scenario 4)
    issue(OP_ALUI, 2'b00, 0, 8, 0, 0, 27'd1, 0);
    settle();
    check("waw_stall", bus.in_ready, 0);
    tick();
    wb(0, 8, 0);
    tick();
    bus.wb_en = 0;
    settle();
    check("waw_release", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    settle();
    check("waw_out", {bus.out_valid, bus.out_rd}, {1'b1, 4'd8});

    // Reset in the middle of a held handshake
    tick();
    bus.out_ready = 0;
    issue(OP_ALU, 2'b00, 0, 12, 3, 0, 0, 0);
    tick();
    bus.in_valid = 0;
    settle();
    check("rst_pre", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {bus.out_valid, bus.out_rd, bus.out_opa}, 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1;
    issue(OP_ALU, 2'b00, 0, 12, 3, 0, 0, 0);
    settle();
    check("rst_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    settle();
    check("rst_rf_zero", {bus.out_valid, bus.out_opa}, {1'b1, 128'h0});

    // Scenario 6: 8-lane / 32-register build, vector r31 round trip
    tick();
    bus8.wb_en = 1; bus8.wb_vf = 1; bus8.wb_rd = 5'd31; bus8.wb_data = V8D;
    tick();
    bus8.wb_en = 0;
    bus8.in_valid = 1; bus8.op = OP_ALU; bus8.inst = 2'b00; bus8.vf = 1;
    bus8.rd = 5'd1; bus8.rs2 = 5'd31; bus8.rs3 = 5'd31;
    settle();
    check("s6_ready", bus8.in_ready, 1);
    tick();
    bus8.in_valid = 0;
    settle();
    check("s6_opa", bus8.out_opa, V8D);
    check("s6_opb", bus8.out_opb, V8D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_decode_stage.md
VECTOR_DECODE_STAGE -- requirements
Module: vector_decode_stage

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): LANES, 4, vector lanes; LANE_W, 32, lane width in bits; NREG, 16, registers per file; IMM_W, 27, immediate width. VW = LANES*LANE_W.
REQ-002 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, single clock; rst_n, in, 1, asynchronous active-low reset.
REQ-003 in_valid in 1, in_ready out 1: input handshake; op in 2, inst in 2, vf in 1 (vector flag), rd/rs2/rs3 in log2(NREG) each, imm in IMM_W, pc in 32.
REQ-004 wb_en in 1, wb_vf in 1, wb_rd in log2(NREG), wb_data in VW: writeback port.
REQ-005 flush in 1: kill held instruction.
REQ-006 out_valid out 1, out_ready in 1: output handshake; out_opa/out_opb out VW; out_rd out log2(NREG); out_vf/out_wreg/out_rmem/out_wmem/out_cond out 1; out_jmp out 2; out_alu out 3.

Function
REQ-007 Decode SHALL be: op=00 ALU reg-reg; op=11 ALU reg-imm; out_alu={op[1],inst}; op=01 memory (inst[0]=1 load: rmem,wreg; 0 store: wmem); op=10 jump (out_jmp=inst; inst=01 sets out_cond; out_wreg=0).
REQ-008 Operand A SHALL be the rs2 read, except for op=10 with inst!=10, where it is {pc} in lane 0.
REQ-009 Operand B SHALL be the rs3 read for op 00 and store; for op 11 and 10 it SHALL be imm sign-extended to LANE_W in lane 0.
REQ-010 When vf=0, scalar values SHALL occupy lane 0 (bits LANE_W-1:0), with the other lanes zero.
REQ-011 Reads SHALL use the vector file when vf=1 and the scalar file otherwise; register 0 of each file SHALL read zero and never be pending.
REQ-012 A scoreboard with one pending bit per register per file SHALL set bit[vf][rd] when an instruction with wreg=1 is accepted, and clear bit[wb_vf][wb_rd] on wb_en.
REQ-013 If set and clear hit the same bit in the same cycle, set SHALL win.
REQ-014 Hazard SHALL be asserted when any used source, or rd when wreg=1 (WAW), is pending in the selected file.
REQ-015 in_ready SHALL equal !hazard && (!out_valid || out_ready) && !flush.
REQ-016 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented with out_valid=1 after edge N.
REQ-017 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-018 flush SHALL clear out_valid next edge, block acceptance that cycle, and clear the scoreboard bit set by the flushed instruction if it had wreg=1; it SHALL have priority over out_ready.
REQ-019 Writeback SHALL write the register file at the clock edge; scalar writes SHALL use wb_data[LANE_W-1:0]; writes to register 0 SHALL be ignored.

Reset
REQ-020 On rst_n=0, asynchronously: out_valid=0; all output fields 0; scoreboard cleared; both register files zeroed. in_ready SHALL be 1 after release.
REQ-021 Reset asserted mid-handshake SHALL discard the held instruction with no writeback side-effects.

Configuration
REQ-022 With DECODE_BYPASS_EN defined, a source matching the same-cycle writeback SHALL read wb_data and not count as a hazard (zero-cycle release).
REQ-023 Without DECODE_BYPASS_EN, such a source SHALL stall one extra cycle and read the file on the following cycle.

Structure
REQ-024 A shared package SHALL hold the op encodings (OP_ALU, OP_MEM, OP_JMP, OP_ALUI), the jump codes, and a decoded-control struct typedef.
REQ-025 The scoreboard SHALL be a sub-module named decode_scoreboard; the register files SHALL be inline arrays.

Verification
REQ-026 Scenario 1: reset, then writeback wb_vf=0, wb_rd=3, data 0x15; then ALU op=00 rs2=3 rs3=0 -> out_opa lane0=0x15 and the other lanes 0, one cycle after acceptance.
REQ-027 Scenario 2: load vf=1 rd=5, then ALU vf=1 rs2=5 -> in_ready=0 until wb_en, wb_vf=1, wb_rd=5; with bypass, accept in the writeback cycle and operand = wb_data; without bypass, accept one cycle later.
REQ-028 Scenario 3: op=11 imm=27'h7FFFFFF -> out_opb lane0=0xFFFFFFFF (LANE_W=32).
REQ-029 Scenario 4: hold out_ready=0 for 3 cycles with in_valid=1 -> output fields stable, in_ready=0, and the second instruction accepted the cycle out_ready rises.
REQ-030 Scenario 5: flush with a held load rd=7 -> out_valid=0 next cycle; a following instruction reading r7 is accepted without stall.
REQ-031 Scenario 6: LANES=8, NREG=32 build; vector writeback to r31, then read r31 -> all 8 lanes match.
